// File: rtl/cpu_pkg.sv
// Shared widths, state encoding and limits for the fetch path.
package cpu_pkg;

    localparam int PC_W     = 12;
    localparam int INSTR_W  = 9;
    localparam int BR_OFF_W = 8;

    localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the instruction ROM and decode.
// FETCH_RETIRE_COUNT_EN adds the retired_count signal.
interface fetch_sequencer_if
    import cpu_pkg::*;
#(
    parameter int D    = PC_W,
    parameter int IW   = INSTR_W,
    parameter int OFFW = BR_OFF_W
);
    logic            start;
    logic [D-1:0]    start_addr;
    logic [D-1:0]    programCounter;
    logic [IW-1:0]   machineCode;
    logic [IW-1:0]   instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            br_taken;
    logic            br_rel;
    logic [D-1:0]    br_target;
    logic [OFFW-1:0] br_offset;
    logic            halt;
    logic            done;
    logic            pc_wrap;
`ifdef FETCH_RETIRE_COUNT_EN
    logic [31:0]     retired_count;

    modport master (
        input  start, start_addr, machineCode, instr_ready,
               br_taken, br_rel, br_target, br_offset, halt,
        output programCounter, instr, instr_valid, done, pc_wrap, retired_count
    );
    modport slave (
        output start, start_addr, machineCode, instr_ready,
               br_taken, br_rel, br_target, br_offset, halt,
        input  programCounter, instr, instr_valid, done, pc_wrap, retired_count
    );
`else
    modport master (
        input  start, start_addr, machineCode, instr_ready,
               br_taken, br_rel, br_target, br_offset, halt,
        output programCounter, instr, instr_valid, done, pc_wrap
    );
    modport slave (
        output start, start_addr, machineCode, instr_ready,
               br_taken, br_rel, br_target, br_offset, halt,
        input  programCounter, instr, instr_valid, done, pc_wrap
    );
`endif
endinterface

// File: rtl/fetch_sequencer_next_pc.sv
// next_pc_calc: combinational next-PC selection for an accepted instruction.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int D    = PC_W,
    parameter int OFFW = BR_OFF_W
) (
    input  logic [D-1:0]    pc,
    input  logic            accept,
    input  logic            halt,
    input  logic            br_taken,
    input  logic            br_rel,
    input  logic [D-1:0]    br_target,
    input  logic [OFFW-1:0] br_offset,
    output logic [D-1:0]    next_pc,
    output logic            wrap
);
    localparam logic [D-1:0] PC_LAST = {D{1'b1}};

    logic [D-1:0] off_ext_s;

    assign off_ext_s = {{(D-OFFW){br_offset[OFFW-1]}}, br_offset};

    // Halt holds the PC; only sequential advance may report a wrap.
    always_comb begin
        next_pc = pc;
        wrap    = 1'b0;
        if (accept && !halt) begin
            if (br_taken) begin
                if (br_rel) begin
                    next_pc = pc + off_ext_s;
                end else begin
                    next_pc = br_target;
                end
            end else begin
                next_pc = pc + {{(D-1){1'b0}}, 1'b1};
                wrap    = (pc == PC_LAST);
            end
        end else begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC and hands ROM words to decode.
// FETCH_RETIRE_COUNT_EN adds a saturating retired-instruction counter.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int D    = PC_W,
    parameter int IW   = INSTR_W,
    parameter int OFFW = BR_OFF_W
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);
    fetch_state_t state_r, state_nxt_s;
    logic [D-1:0] pc_r, pc_nxt_s, calc_pc_s;
    logic         valid_r, done_r, wrap_r, wrap_nxt_s;
    logic         accept_s, calc_wrap_s;
`ifdef FETCH_RETIRE_COUNT_EN
    logic [31:0]  retired_r, retired_nxt_s;
`endif

    assign accept_s = valid_r & bus.instr_ready;

    next_pc_calc #(.D(D), .OFFW(OFFW)) u_next_pc (
        .pc        (pc_r),
        .accept    (accept_s),
        .halt      (bus.halt),
        .br_taken  (bus.br_taken),
        .br_rel    (bus.br_rel),
        .br_target (bus.br_target),
        .br_offset (bus.br_offset),
        .next_pc   (calc_pc_s),
        .wrap      (calc_wrap_s)
    );

    // Next-state, PC and flag selection.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        wrap_nxt_s  = wrap_r;
`ifdef FETCH_RETIRE_COUNT_EN
        retired_nxt_s = retired_r;
`endif
        case (state_r)
            IDLE, HALTED: begin
                if (bus.start) begin
                    state_nxt_s = RUN;
                    pc_nxt_s    = bus.start_addr;
                    wrap_nxt_s  = 1'b0;
`ifdef FETCH_RETIRE_COUNT_EN
                    retired_nxt_s = 32'd0;
`endif
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RUN: begin
                if (accept_s) begin
                    pc_nxt_s   = calc_pc_s;
                    wrap_nxt_s = wrap_r | calc_wrap_s;
                    if (bus.halt) begin
                        state_nxt_s = HALTED;
                    end else begin
                        state_nxt_s = RUN;
                    end
`ifdef FETCH_RETIRE_COUNT_EN
                    if (retired_r != 32'hFFFF_FFFF) begin
                        retired_nxt_s = retired_r + 32'd1;
                    end else begin
                        retired_nxt_s = retired_r;
                    end
`endif
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pc_nxt_s    = {D{1'b0}};
                wrap_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, PC and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            pc_r    <= {D{1'b0}};
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            wrap_r  <= 1'b0;
`ifdef FETCH_RETIRE_COUNT_EN
            retired_r <= 32'd0;
`endif
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            valid_r <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == HALTED);
            wrap_r  <= wrap_nxt_s;
`ifdef FETCH_RETIRE_COUNT_EN
            retired_r <= retired_nxt_s;
`endif
        end
    end

    assign bus.programCounter = pc_r;
    assign bus.instr          = bus.machineCode;
    assign bus.instr_valid    = valid_r;
    assign bus.done           = done_r;
    assign bus.pc_wrap        = wrap_r;
`ifdef FETCH_RETIRE_COUNT_EN
    assign bus.retired_count  = retired_r;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand
// sequences and a randomized run against an abstract reference model.
module tb_fetch_sequencer;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [8:0] rom [0:4095];

    fetch_sequencer_if #(.D(12), .IW(9), .OFFW(8)) bus ();

    fetch_sequencer #(.D(12), .IW(9), .OFFW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.machineCode = rom[bus.programCounter];

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, start;
        logic [11:0] saddr;
        logic        rdy, bt, brel;
        logic [11:0] btgt;
        logic [7:0]  boff;
        logic        hlt;
        logic [11:0] e_pc;
        logic        e_v, e_d, e_w;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic start, input logic [11:0] saddr,
                                input logic rdy, input logic bt, input logic brel,
                                input logic [11:0] btgt, input logic [7:0] boff, input logic hlt,
                                input logic [11:0] e_pc, input logic e_v, input logic e_d,
                                input logic e_w);
        vec_t v;
        v.rst = rst; v.start = start; v.saddr = saddr; v.rdy = rdy; v.bt = bt;
        v.brel = brel; v.btgt = btgt; v.boff = boff; v.hlt = hlt;
        v.e_pc = e_pc; v.e_v = e_v; v.e_d = e_d; v.e_w = e_w;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample 1 ns later.
    task automatic apply(input logic rst, input logic start, input logic [11:0] saddr,
                         input logic rdy, input logic bt, input logic brel,
                         input logic [11:0] btgt, input logic [7:0] boff, input logic hlt);
        reset           = rst;
        bus.start       = start;
        bus.start_addr  = saddr;
        bus.instr_ready = rdy;
        bus.br_taken    = bt;
        bus.br_rel      = brel;
        bus.br_target   = btgt;
        bus.br_offset   = boff;
        bus.halt        = hlt;
        @(posedge clk);
        #1;
    endtask

    // Reference model: program-level view of the fetch unit.
    bit      m_run, m_halt, m_wrap;
    int      m_pc;
    longint  m_cnt;

    function automatic void model_step(input logic rst, input logic start, input logic [11:0] saddr,
                                       input logic rdy, input logic bt, input logic brel,
                                       input logic [11:0] btgt, input logic [7:0] boff,
                                       input logic hlt);
        if (rst) begin
            m_run = 0; m_halt = 0; m_pc = 0; m_wrap = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_halt = 0; m_pc = int'(saddr); m_wrap = 0; m_cnt = 0;
            end
        end else if (rdy) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (hlt) begin
                m_run = 0; m_halt = 1;
            end else if (bt && brel) begin
                m_pc = (m_pc + int'($signed(boff)) + 4096) % 4096;
            end else if (bt) begin
                m_pc = int'(btgt);
            end else begin
                if (m_pc == int'(PC_MAX)) m_wrap = 1;
                m_pc = (m_pc + 1) % 4096;
            end
        end
    endfunction

    initial begin
        logic [11:0] pc_e;
        for (int i = 0; i < 4096; i++) rom[i] = 9'($urandom);

        // Directed table covering the main scenarios.
        add(1,0,12'h000,1,0,0,12'h000,8'h00,0, 12'h000,0,0,0);
        add(0,0,12'h000,1,1,0,12'h333,8'h00,1, 12'h000,0,0,0);
        add(0,1,12'h000,1,0,0,12'h000,8'h00,0, 12'h000,1,0,0);
        for (int p = 1; p <= 3; p++) add(0,0,12'h000,1,0,0,12'h000,8'h00,0, 12'(p),1,0,0);
        for (int k = 0; k < 3; k++)  add(0,0,12'h000,0,1,0,12'h777,8'h00,1, 12'h003,1,0,0);
        for (int p = 4; p <= 10; p++) add(0,0,12'h000,1,0,0,12'h000,8'h00,0, 12'(p),1,0,0);
        add(0,0,12'h000,1,1,0,12'h200,8'h00,0, 12'h200,1,0,0);
        add(0,0,12'h000,1,1,1,12'h000,8'hFC,0, 12'h1FC,1,0,0);
        add(0,0,12'h000,1,1,0,12'h000,8'h00,0, 12'h000,1,0,0);
        add(0,0,12'h000,1,1,1,12'h000,8'hFF,0, 12'hFFF,1,0,0);
        add(0,0,12'h000,1,0,0,12'h000,8'h00,0, 12'h000,1,0,1);
        add(0,0,12'h000,1,1,0,12'h007,8'h00,0, 12'h007,1,0,1);
        add(0,0,12'h000,1,1,0,12'h444,8'h00,1, 12'h007,0,1,1);
        add(0,0,12'h000,1,0,0,12'h000,8'h00,0, 12'h007,0,1,1);
        add(0,1,12'h020,1,0,0,12'h000,8'h00,0, 12'h020,1,0,0);
        add(0,0,12'h000,1,0,0,12'h000,8'h00,0, 12'h021,1,0,0);
        add(0,0,12'h000,1,1,0,12'h050,8'h00,0, 12'h050,1,0,0);
        add(1,1,12'h123,1,0,0,12'h000,8'h00,0, 12'h000,0,0,0);
        add(0,1,12'hFFE,1,0,0,12'h000,8'h00,0, 12'hFFE,1,0,0);
        add(0,0,12'h000,1,0,0,12'h000,8'h00,0, 12'hFFF,1,0,0);
        add(0,0,12'h000,1,0,0,12'h000,8'h00,0, 12'h000,1,0,1);
        add(0,0,12'h000,1,0,0,12'h000,8'h00,0, 12'h001,1,0,1);
        add(0,1,12'h123,0,0,0,12'h000,8'h00,0, 12'h001,1,0,1);
        add(0,0,12'h000,1,0,0,12'h000,8'h00,1, 12'h001,0,1,1);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].start, vecs[i].saddr, vecs[i].rdy, vecs[i].bt,
                  vecs[i].brel, vecs[i].btgt, vecs[i].boff, vecs[i].hlt);
            chk($sformatf("vec%0d_pc", i),    32'(bus.programCounter), 32'(vecs[i].e_pc));
            chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid),    32'(vecs[i].e_v));
            chk($sformatf("vec%0d_done", i),  32'(bus.done),           32'(vecs[i].e_d));
            chk($sformatf("vec%0d_wrap", i),  32'(bus.pc_wrap),        32'(vecs[i].e_w));
            if (vecs[i].e_v) chk($sformatf("vec%0d_instr", i), 32'(bus.instr), 32'(rom[vecs[i].e_pc]));
        end

`ifdef FETCH_RETIRE_COUNT_EN
        // Six sequential accepts plus the halting one retire seven.
        apply(1,0,12'h000,0,0,0,12'h000,8'h00,0);
        apply(0,1,12'h000,0,0,0,12'h000,8'h00,0);
        chk("retired_after_start", bus.retired_count, 32'd0);
        for (int k = 0; k < 6; k++) apply(0,0,12'h000,1,0,0,12'h000,8'h00,0);
        chk("retired_six", bus.retired_count, 32'd6);
        apply(0,0,12'h000,1,0,0,12'h000,8'h00,1);
        chk("retired_halt", bus.retired_count, 32'd7);
        chk("retired_done", 32'(bus.done), 32'd1);
`endif

        // Randomized run against the reference model.
        m_run = 0; m_halt = 0; m_pc = 0; m_wrap = 0; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_start, r_rdy, r_bt, r_brel, r_hlt;
            logic [11:0] r_saddr, r_btgt;
            logic [7:0]  r_boff;
            r_rst   = (c == 0) || ($urandom_range(0, 199) == 0);
            r_start = ($urandom_range(0, 7) == 0);
            r_saddr = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3)) : 12'($urandom);
            r_rdy   = ($urandom_range(0, 3) != 0);
            r_bt    = ($urandom_range(0, 3) == 0);
            r_brel  = 1'($urandom);
            r_btgt  = 12'($urandom);
            r_boff  = 8'($urandom);
            r_hlt   = ($urandom_range(0, 31) == 0);
            apply(r_rst, r_start, r_saddr, r_rdy, r_bt, r_brel, r_btgt, r_boff, r_hlt);
            model_step(r_rst, r_start, r_saddr, r_rdy, r_bt, r_brel, r_btgt, r_boff, r_hlt);
            pc_e = 12'(m_pc);
            chk("rand_pc",    32'(bus.programCounter), 32'(pc_e));
            chk("rand_valid", 32'(bus.instr_valid),    32'(m_run));
            chk("rand_done",  32'(bus.done),           32'(m_halt));
            chk("rand_wrap",  32'(bus.pc_wrap),        32'(m_wrap));
            if (m_run) chk("rand_instr", 32'(bus.instr), 32'(rom[pc_e]));
`ifdef FETCH_RETIRE_COUNT_EN
            chk("rand_retired", bus.retired_count, 32'(m_cnt));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
